// File: rtl/enigma_pkg.sv
// Shared types and helpers for the Enigma rotor datapath.
// A single-rotor 0..25 counter is this stack with NUM_ROTORS=1.
package enigma_pkg;

    localparam int unsigned ALPHABET_SIZE = 26;

    typedef enum logic [1:0] {
        StIdle,
        StStep,
        StDone
    } rotor_state_e;

    function automatic int unsigned wrap_inc(input int unsigned pos, input int unsigned modulus);
        return (pos == modulus - 32'd1) ? 32'd0 : pos + 32'd1;
    endfunction

endpackage

// File: rtl/enigma_rotor_stack_if.sv
// Keystroke/load bus between the keypress conditioner, the rotor stack and the substitution path.
interface enigma_rotor_stack_if #(
    parameter int unsigned NUM_ROTORS = 3,
    parameter int unsigned POS_W      = 5,
    parameter int unsigned CNT_W      = 16
);
    logic                        load;
    logic [NUM_ROTORS*POS_W-1:0] init_pos;
    logic [NUM_ROTORS*POS_W-1:0] notch_pos;
    logic                        step_req;
    logic [NUM_ROTORS*POS_W-1:0] rotor_pos;
    logic                        step_done;
    logic [NUM_ROTORS-1:0]       load_err;
    logic [CNT_W-1:0]            key_count;

    modport master (
        output load, init_pos, notch_pos, step_req,
        input  rotor_pos, step_done, load_err, key_count
    );

    modport slave (
        input  load, init_pos, notch_pos, step_req,
        output rotor_pos, step_done, load_err, key_count
    );
endinterface

// File: rtl/enigma_rotor_cell.sv
// One rotor: registered position with load, mod-ALPHABET step and notch detect.
module enigma_rotor_cell
    import enigma_pkg::*;
#(
    parameter int unsigned ALPHABET = ALPHABET_SIZE,
    parameter int unsigned POS_W    = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             step_en_i,
    input  logic             load_i,
    input  logic [POS_W-1:0] init_val_i,
    input  logic [POS_W-1:0] notch_i,
    output logic [POS_W-1:0] pos_o,
    output logic             at_notch_o,
    output logic             load_err_o
);

    // One extra bit so ALPHABET == 2**POS_W is representable.
    localparam logic [POS_W:0] AlphaLim = (POS_W + 1)'(ALPHABET);

    logic [POS_W-1:0] pos_q, pos_d;
    logic             load_err_q, load_err_d;
    logic             init_ok;

    assign init_ok = {1'b0, init_val_i} < AlphaLim;

    always_comb begin
        pos_d      = pos_q;
        load_err_d = load_err_q;
        if (load_i) begin
            pos_d      = init_ok ? init_val_i : '0;
            load_err_d = ~init_ok;
        end else if (step_en_i) begin
            pos_d = POS_W'(wrap_inc(32'(pos_q), ALPHABET));
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pos_q      <= '0;
            load_err_q <= 1'b0;
        end else begin
            pos_q      <= pos_d;
            load_err_q <= load_err_d;
        end
    end

    assign pos_o      = pos_q;
    assign load_err_o = load_err_q;
    assign at_notch_o = (pos_q == notch_i) && ({1'b0, notch_i} < AlphaLim);

endmodule

// File: rtl/enigma_rotor_stack.sv
// Rotor stack: keypress edge detect, IDLE/STEP/DONE sequencer, step mask and keystroke counter.
module enigma_rotor_stack
    import enigma_pkg::*;
#(
    parameter int unsigned NUM_ROTORS  = 3,
    parameter int unsigned ALPHABET    = ALPHABET_SIZE,
    parameter int unsigned POS_W       = 5,
    parameter int unsigned DOUBLE_STEP = 1,
    parameter int unsigned CNT_W       = 16
) (
    input logic                 clk,
    input logic                 reset,
    enigma_rotor_stack_if.slave bus
);

    rotor_state_e            state_q, state_d;
    logic                    req_q;
    logic                    step_done_q, step_done_d;
    logic [CNT_W-1:0]        key_count_q, key_count_d;
    logic [NUM_ROTORS-1:0]   at_notch, step_mask, step_en, load_err;
    logic                    req_edge;

    assign req_edge = bus.step_req & ~req_q;

    // Carry only propagates out of a rotor that is itself stepping; with double-stepping a
    // middle rotor sitting on its notch steps on its own, which also lets it carry.
    always_comb begin
        logic carry;
        step_mask = '0;
        carry     = 1'b1;
        for (int i = 0; i < int'(NUM_ROTORS); i++) begin
            step_mask[i] = carry;
            if (DOUBLE_STEP != 0 && i >= 1 && i + 2 <= int'(NUM_ROTORS) && at_notch[i]) begin
                step_mask[i] = 1'b1;
            end
            carry = step_mask[i] & at_notch[i];
        end
    end

    assign step_en = step_mask & {NUM_ROTORS{state_q == StStep}};

    always_comb begin
        state_d     = state_q;
        step_done_d = 1'b0;
        key_count_d = key_count_q;
        if (bus.load) begin
            state_d     = StIdle;
            key_count_d = '0;
        end else begin
            unique case (state_q)
                StIdle: if (req_edge) state_d = StStep;
                StStep: begin
                    state_d     = StDone;
                    step_done_d = 1'b1;
                    key_count_d = key_count_q + 1'b1;
                end
                StDone:  state_d = StIdle;
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            req_q       <= 1'b0;
            step_done_q <= 1'b0;
            key_count_q <= '0;
        end else begin
            state_q     <= state_d;
            req_q       <= bus.step_req;
            step_done_q <= step_done_d;
            key_count_q <= key_count_d;
        end
    end

    for (genvar i = 0; i < NUM_ROTORS; i++) begin : g_rotor
        enigma_rotor_cell #(
            .ALPHABET (ALPHABET),
            .POS_W    (POS_W)
        ) u_cell (
            .clk        (clk),
            .reset      (reset),
            .step_en_i  (step_en[i]),
            .load_i     (bus.load),
            .init_val_i (bus.init_pos[i*POS_W +: POS_W]),
            .notch_i    (bus.notch_pos[i*POS_W +: POS_W]),
            .pos_o      (bus.rotor_pos[i*POS_W +: POS_W]),
            .at_notch_o (at_notch[i]),
            .load_err_o (load_err[i])
        );
    end

    assign bus.step_done = step_done_q;
    assign bus.key_count = key_count_q;
    assign bus.load_err  = load_err;

endmodule

// File: tb/tb_enigma_rotor_stack.sv
// Directed bench for enigma_rotor_stack; a second instance runs with DOUBLE_STEP=0.
module tb_enigma_rotor_stack;

    logic clk;
    logic reset;
    int   n_tests;
    int   n_fail;
    int   done_cnt;
    int   done_base;

    enigma_rotor_stack_if #(.NUM_ROTORS(3), .POS_W(5), .CNT_W(16)) bus ();
    enigma_rotor_stack_if #(.NUM_ROTORS(3), .POS_W(5), .CNT_W(16)) bus_ns ();

    assign bus_ns.load      = bus.load;
    assign bus_ns.init_pos  = bus.init_pos;
    assign bus_ns.notch_pos = bus.notch_pos;
    assign bus_ns.step_req  = bus.step_req;

    enigma_rotor_stack #(
        .NUM_ROTORS (3), .ALPHABET (26), .POS_W (5), .DOUBLE_STEP (1), .CNT_W (16)
    ) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    enigma_rotor_stack #(
        .NUM_ROTORS (3), .ALPHABET (26), .POS_W (5), .DOUBLE_STEP (0), .CNT_W (16)
    ) u_dut_ns (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_ns)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial done_cnt = 0;
    always @(posedge clk) if (bus.step_done) done_cnt <= done_cnt + 1;

    function automatic logic [14:0] pk(input int r0, input int r1, input int r2);
        logic [4:0] a, b, c;
        a = 5'(r0);
        b = 5'(r1);
        c = 5'(r2);
        return {c, b, a};
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    // All tasks start and end just after a falling edge.
    task automatic do_load(input logic [14:0] init, input logic [14:0] notch);
        bus.load      = 1'b1;
        bus.init_pos  = init;
        bus.notch_pos = notch;
        @(negedge clk);
        bus.load = 1'b0;
    endtask

    task automatic press(input int hold);
        bus.step_req = 1'b1;
        repeat (hold) @(negedge clk);
        bus.step_req = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        n_tests       = 0;
        n_fail        = 0;
        reset         = 1'b1;
        bus.load      = 1'b0;
        bus.init_pos  = '0;
        bus.notch_pos = '0;
        bus.step_req  = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        check_eq("rst_pos", 32'(bus.rotor_pos), 0);
        check_eq("rst_done", 32'(bus.step_done), 0);
        check_eq("rst_key", 32'(bus.key_count), 0);
        check_eq("rst_err", 32'(bus.load_err), 0);

        // Basic step and latency
        do_load(pk(0, 0, 0), pk(16, 4, 21));
        done_base    = done_cnt;
        bus.step_req = 1'b1;
        @(negedge clk);
        check_eq("t1_step_not_yet", 32'(bus.step_done), 0);
        @(negedge clk);
        check_eq("t1_done_pulse", 32'(bus.step_done), 1);
        check_eq("t1_pos", 32'(bus.rotor_pos), 32'(pk(1, 0, 0)));
        bus.step_req = 1'b0;
        repeat (4) @(negedge clk);
        check_eq("t1_done_once", 32'(done_cnt - done_base), 1);
        check_eq("t1_key", 32'(bus.key_count), 1);

        // Carry out of rotor 0
        do_load(pk(16, 0, 0), pk(16, 4, 21));
        check_eq("t2_key_clr", 32'(bus.key_count), 0);
        press(1);
        check_eq("t2_carry", 32'(bus.rotor_pos), 32'(pk(17, 1, 0)));
        do_load(pk(25, 0, 0), pk(25, 4, 21));
        press(1);
        check_eq("t2_wrap_carry", 32'(bus.rotor_pos), 32'(pk(0, 1, 0)));

        // Double step vs. pure odometer
        do_load(pk(16, 3, 0), pk(16, 4, 21));
        press(1);
        check_eq("t3_step1", 32'(bus.rotor_pos), 32'(pk(17, 4, 0)));
        check_eq("t3_step1_ns", 32'(bus_ns.rotor_pos), 32'(pk(17, 4, 0)));
        press(1);
        check_eq("t3_double", 32'(bus.rotor_pos), 32'(pk(18, 5, 1)));
        check_eq("t3_odometer", 32'(bus_ns.rotor_pos), 32'(pk(18, 4, 0)));

        // Notch beyond alphabet never carries
        do_load(pk(5, 0, 0), pk(30, 4, 21));
        repeat (26) press(1);
        check_eq("t3_bad_notch", 32'(bus.rotor_pos), 32'(pk(5, 0, 0)));

        // Out-of-range load
        do_load(pk(3, 30, 4), pk(16, 4, 21));
        check_eq("t4_err", 32'(bus.load_err), 32'b010);
        check_eq("t4_pos", 32'(bus.rotor_pos), 32'(pk(3, 0, 4)));
        do_load(pk(3, 7, 4), pk(16, 4, 21));
        check_eq("t4_err_clr", 32'(bus.load_err), 0);
        check_eq("t4_pos_ok", 32'(bus.rotor_pos), 32'(pk(3, 7, 4)));

        // Held level and edge during DONE
        do_load(pk(0, 0, 0), pk(16, 4, 21));
        done_base = done_cnt;
        press(10);
        check_eq("t5_hold_done", 32'(done_cnt - done_base), 1);
        check_eq("t5_hold_key", 32'(bus.key_count), 1);
        bus.step_req = 1'b1;
        @(negedge clk);
        bus.step_req = 1'b0;
        @(negedge clk);
        bus.step_req = 1'b1;
        @(negedge clk);
        bus.step_req = 1'b0;
        repeat (4) @(negedge clk);
        check_eq("t5_drop_key", 32'(bus.key_count), 2);
        check_eq("t5_drop_done", 32'(done_cnt - done_base), 2);
        check_eq("t5_drop_pos", 32'(bus.rotor_pos), 32'(pk(2, 0, 0)));

        // Load aborts a step in progress
        done_base    = done_cnt;
        bus.step_req = 1'b1;
        @(negedge clk);
        bus.step_req = 1'b0;
        do_load(pk(5, 6, 7), pk(16, 4, 21));
        check_eq("t6_abort_pos", 32'(bus.rotor_pos), 32'(pk(5, 6, 7)));
        check_eq("t6_abort_done", 32'(bus.step_done), 0);
        check_eq("t6_abort_key", 32'(bus.key_count), 0);
        repeat (3) @(negedge clk);
        check_eq("t6_abort_no_pulse", 32'(done_cnt - done_base), 0);

        // Async reset while in DONE
        do_load(pk(1, 30, 3), pk(16, 4, 21));
        bus.step_req = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check_eq("t6_pre_rst_done", 32'(bus.step_done), 1);
        check_eq("t6_pre_rst_err", 32'(bus.load_err), 32'b010);
        reset = 1'b1;
        #1;
        check_eq("t6_rst_pos", 32'(bus.rotor_pos), 0);
        check_eq("t6_rst_done", 32'(bus.step_done), 0);
        check_eq("t6_rst_key", 32'(bus.key_count), 0);
        check_eq("t6_rst_err", 32'(bus.load_err), 0);
        bus.step_req = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
